// File: rtl/led_sched_pkg.sv
// ----------------------------------------------------------------------------
// led_sched_pkg
// Shared types and constants for the LED pattern sequencer:
//   - mode_e  : command pattern select (off / running light / count / blink)
//   - state_e : sequencer FSM states
//   - initial patterns and period lengths (in steps) for each mode
//   - helper functions that map a mode to its initial pattern, its last
//     step index within a period, and its step rule
// ----------------------------------------------------------------------------
package led_sched_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_CNT   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [3:0] INIT_RUN   = 4'b0001;
    localparam logic [3:0] INIT_CNT   = 4'b0000;
    localparam logic [3:0] INIT_BLINK = 4'b1111;

    localparam int PERIOD_RUN   = 4;
    localparam int PERIOD_CNT   = 16;
    localparam int PERIOD_BLINK = 2;

    function automatic logic [3:0] init_pattern(input mode_e mode);
        case (mode)
            MODE_RUN:   return INIT_RUN;
            MODE_CNT:   return INIT_CNT;
            MODE_BLINK: return INIT_BLINK;
            default:    return 4'b0000;
        endcase
    endfunction

    // Index of the final step in one period; the step taken from this index
    // is the one that brings the pattern back to its initial value.
    function automatic logic [3:0] period_last(input mode_e mode);
        case (mode)
            MODE_RUN:   return 4'(PERIOD_RUN - 1);
            MODE_CNT:   return 4'(PERIOD_CNT - 1);
            MODE_BLINK: return 4'(PERIOD_BLINK - 1);
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] step_pattern(input mode_e mode, input logic [3:0] pat);
        case (mode)
            MODE_RUN:   return {pat[2:0], pat[3]};
            MODE_CNT:   return pat + 4'd1;
            MODE_BLINK: return ~pat;
            default:    return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_sched_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-TICK_DIV counter with a synchronous clear. The tick
// output is registered and is high during the cycle whose closing edge is
// the one where the count wraps, so logic consuming it acts on that edge.
// After a clear edge E0, those edges are E0+TICK_DIV, E0+2*TICK_DIV, ...
// Ports:
//   clk   in  : system clock
//   rst_n in  : synchronous active-low reset (clears count and tick)
//   clr   in  : restart the count from zero at this edge
//   tick  out : registered step-enable pulse
// ----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    always_comb begin
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            // Registering the compare against the next count keeps the
            // pulse aligned with the cycle in which cnt_q sits at its top.
            tick_q <= (cnt_d == CNT_W'(TICK_DIV - 1));
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_sched.sv
// ----------------------------------------------------------------------------
// led_pattern_sched
// Command-driven sequencer for the 4-bit LED bank. Accepts one pattern
// command over valid/ready, steps the pattern once per prescaler tick for
// the requested number of periods (0 = until abort), then pulses done.
// Optional build macro: LED_SCHED_ACTIVE_LOW_EN drives led with the inverse
// of the internal pattern (idle/reset level 1111).
// Ports:
//   clk        in      : system clock
//   rst_n      in      : synchronous active-low reset
//   cmd_valid  in      : command present
//   cmd_ready  out     : high while idle
//   cmd_mode   in  [2] : 0 off, 1 running light, 2 binary count, 3 blink
//   cmd_repeat in  [8] : full periods to run, 0 = forever
//   abort      in      : stop the running command without done
//   led        out [4] : LED drive (registered)
//   busy       out     : high while running (registered)
//   done       out     : one-cycle pulse on normal completion (registered)
// ----------------------------------------------------------------------------
module led_pattern_sched
    import led_sched_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_repeat,
    input  logic       abort,
    output logic [3:0] led,
    output logic       busy,
    output logic       done
);

`ifdef LED_SCHED_ACTIVE_LOW_EN
    localparam logic [3:0] LED_POLARITY = 4'b1111;
`else
    localparam logic [3:0] LED_POLARITY = 4'b0000;
`endif

    state_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    logic [7:0] rep_q, rep_d;
    logic [3:0] step_q, step_d;
    logic [3:0] pat_q, pat_d;
    logic       done_q, done_d;
    logic       busy_q;
    logic [3:0] led_q;
    logic       accept;
    logic       tick;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .tick  (tick)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        rep_d   = rep_q;
        step_d  = step_q;
        pat_d   = pat_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mode_e'(cmd_mode) == MODE_OFF) begin
                        pat_d  = 4'b0000;
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        mode_d  = mode_e'(cmd_mode);
                        rep_d   = cmd_repeat;
                        step_d  = 4'd0;
                        pat_d   = init_pattern(mode_e'(cmd_mode));
                    end
                end
            end
            ST_RUN: begin
                // Abort outranks everything, including a period-end tick.
                if (abort) begin
                    state_d = ST_IDLE;
                    pat_d   = 4'b0000;
                end else if (tick) begin
                    if (step_q == period_last(mode_q)) begin
                        if (rep_q == 8'd1) begin
                            state_d = ST_IDLE;
                            pat_d   = 4'b0000;
                            done_d  = 1'b1;
                        end else begin
                            // rep_q == 0 means run forever: never decrement.
                            if (rep_q != 8'd0) begin
                                rep_d = rep_q - 8'd1;
                            end
                            step_d = 4'd0;
                            pat_d  = step_pattern(mode_q, pat_q);
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                        pat_d  = step_pattern(mode_q, pat_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pat_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            rep_q   <= 8'd0;
            step_q  <= 4'd0;
            pat_q   <= 4'b0000;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            led_q   <= LED_POLARITY;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rep_q   <= rep_d;
            step_q  <= step_d;
            pat_q   <= pat_d;
            done_q  <= done_d;
            busy_q  <= (state_d == ST_RUN);
            led_q   <= pat_d ^ LED_POLARITY;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_sched
// Self-checking bench for led_pattern_sched with TICK_DIV = 4. A vector table
// covers reset, the off command and a full running-light command cycle by
// cycle; hand-written sequences cover blink with repeat, endless count with
// abort, abort on a period end, back-pressure and reset mid-run.
// ----------------------------------------------------------------------------
module tb_led_pattern_sched;

    localparam int TICK_DIV = 4;

`ifdef LED_SCHED_ACTIVE_LOW_EN
    localparam logic [3:0] LED_XOR = 4'b1111;
`else
    localparam logic [3:0] LED_XOR = 4'b0000;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_repeat;
    logic       abort;
    logic [3:0] led;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    led_pattern_sched #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_repeat (cmd_repeat),
        .abort      (abort),
        .led        (led),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // done is a one-cycle pulse, so one sample per cycle counts each pulse once.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [1:0] mode;
        logic [7:0] rep;
        logic       abort;
        logic [3:0] exp_led;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_ready;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] e_led, input logic e_busy,
                             input logic e_done, input logic e_ready);
        check({name, ".led"},   {4'b0, led},       {4'b0, e_led ^ LED_XOR});
        check({name, ".busy"},  {7'b0, busy},      {7'b0, e_busy});
        check({name, ".done"},  {7'b0, done},      {7'b0, e_done});
        check({name, ".ready"}, {7'b0, cmd_ready}, {7'b0, e_ready});
    endtask

    task automatic add(input logic r, input logic v, input logic [1:0] m, input logic [7:0] rp,
                       input logic a, input logic [3:0] el, input logic eb, input logic ed,
                       input logic er, input string nm);
        vec_t x;
        x.rst_n = r; x.valid = v; x.mode = m; x.rep = rp; x.abort = a;
        x.exp_led = el; x.exp_busy = eb; x.exp_done = ed; x.exp_ready = er; x.name = nm;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] rp, input logic a);
        cmd_valid = v; cmd_mode = m; cmd_repeat = rp; abort = a;
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        logic [3:0] one;
        one = 4'b0001;
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'd0, 1'b0);

        // Reset, off command, then running light repeat=1, one row per edge.
        add(0, 0, 2'd0, 8'd0, 0, 4'b0000, 0, 0, 1, "reset0");
        add(0, 1, 2'd1, 8'd1, 1, 4'b0000, 0, 0, 1, "reset1");
        add(1, 1, 2'd0, 8'd5, 0, 4'b0000, 0, 1, 1, "off_cmd");
        add(1, 0, 2'd0, 8'd0, 0, 4'b0000, 0, 0, 1, "off_after");
        add(1, 0, 2'd0, 8'd0, 1, 4'b0000, 0, 0, 1, "abort_idle");
        add(1, 1, 2'd1, 8'd1, 0, 4'b0001, 1, 0, 0, "run_e0");
        for (int e = 1; e <= 16; e++) begin
            add(1, 0, 2'd0, 8'd0, 0, (e < 16) ? (one << (e / 4)) : 4'b0000,
                e < 16, e == 16, e == 16, $sformatf("run_e%0d", e));
        end
        add(1, 0, 2'd0, 8'd0, 0, 4'b0000, 0, 0, 1, "run_e17");

        #2;
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            drive(vecs[i].valid, vecs[i].mode, vecs[i].rep, vecs[i].abort);
            edges(1);
            check_out(vecs[i].name, vecs[i].exp_led, vecs[i].exp_busy,
                      vecs[i].exp_done, vecs[i].exp_ready);
        end
        drive(1'b0, 2'd0, 8'd0, 1'b0);

        // Blink, repeat=2: done at E16.
        drive(1'b1, 2'd3, 8'd2, 1'b0);
        edges(1);  check_out("blink_e0", 4'b1111, 1, 0, 0);
        drive(1'b0, 2'd0, 8'd0, 1'b0);
        edges(4);  check_out("blink_e4", 4'b0000, 1, 0, 0);
        edges(4);  check_out("blink_e8", 4'b1111, 1, 0, 0);
        edges(4);  check_out("blink_e12", 4'b0000, 1, 0, 0);
        edges(3);  check_out("blink_e15", 4'b0000, 1, 0, 0);
        edges(1);  check_out("blink_e16", 4'b0000, 0, 1, 1);
        edges(1);  check_out("blink_e17", 4'b0000, 0, 0, 1);

        // Count, repeat=0, abort sampled at E21.
        d0 = done_cnt;
        drive(1'b1, 2'd2, 8'd0, 1'b0);
        edges(1);  check_out("cnt_e0", 4'b0000, 1, 0, 0);
        drive(1'b0, 2'd0, 8'd0, 1'b0);
        edges(20); check_out("cnt_e20", 4'b0101, 1, 0, 0);
        abort = 1'b1;
        edges(1);  check_out("cnt_abort", 4'b0000, 0, 0, 1);
        abort = 1'b0;
        edges(40);
        check("cnt_no_done", 8'(done_cnt - d0), 8'd0);

        // Abort coincident with the period-end tick of blink repeat=1 (E8).
        d0 = done_cnt;
        drive(1'b1, 2'd3, 8'd1, 1'b0);
        edges(1);
        drive(1'b0, 2'd0, 8'd0, 1'b0);
        edges(7);  check_out("pe_abort_e7", 4'b0000, 1, 0, 0);
        abort = 1'b1;
        edges(1);  check_out("pe_abort_e8", 4'b0000, 0, 0, 1);
        abort = 1'b0;
        edges(3);
        check("pe_abort_no_done", 8'(done_cnt - d0), 8'd0);

        // Back-pressure: mode 1 held valid during a blink run.
        drive(1'b1, 2'd3, 8'd1, 1'b0);
        edges(1);  check_out("bp_e0", 4'b1111, 1, 0, 0);
        drive(1'b1, 2'd1, 8'd1, 1'b0);
        edges(3);  check_out("bp_e3", 4'b1111, 1, 0, 0);
        edges(1);  check_out("bp_e4", 4'b0000, 1, 0, 0);
        edges(4);  check_out("bp_e8", 4'b0000, 0, 1, 1);
        edges(1);  check_out("bp_e9", 4'b0001, 1, 0, 0);
        drive(1'b0, 2'd0, 8'd0, 1'b0);
        edges(15); check_out("bp_e24", 4'b1000, 1, 0, 0);
        edges(1);  check_out("bp_e25", 4'b0000, 0, 1, 1);

        // Reset mid-run at E6, then a fresh repeat=3 command.
        drive(1'b1, 2'd1, 8'd1, 1'b0);
        edges(1);
        drive(1'b0, 2'd0, 8'd0, 1'b0);
        edges(5);  check_out("rst_e5", 4'b0010, 1, 0, 0);
        d0 = done_cnt;
        rst_n = 1'b0;
        edges(1);  check_out("rst_e6", 4'b0000, 0, 0, 1);
        rst_n = 1'b1;
        edges(20);
        check("rst_no_done", 8'(done_cnt - d0), 8'd0);
        drive(1'b1, 2'd1, 8'd3, 1'b0);
        edges(1);  check_out("rst_new_e0", 4'b0001, 1, 0, 0);
        drive(1'b0, 2'd0, 8'd0, 1'b0);
        edges(47); check_out("rst_new_e47", 4'b1000, 1, 0, 0);
        edges(1);  check_out("rst_new_e48", 4'b0000, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_sched.md
# led_pattern_sched

Command-driven sequencer that owns the board's 4-bit LED bank and steps it through one of several animation patterns at a prescaled rate. It sits between the top-level control logic and the `led[3:0]` pins. It accepts one pattern command at a time over a valid/ready handshake, runs the command for a programmed number of pattern periods (or indefinitely), then signals completion.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per pattern step; legal range ≥2; benches use 4.
- `CNT_W`, default `$clog2(TICK_DIV)`: prescaler width.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_mode` in 2: pattern select.
  - 0 = off
  - 1 = running light
  - 2 = binary count
  - 3 = blink-all
- `cmd_repeat` in 8: number of full pattern periods; 0 = run until abort.
- `abort` in 1: stop the current command.
- `led` out 4: LED drive.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse on normal completion.

## Operation
- FSM states: IDLE, RUN.
- Reset (`rst_n`=0 at an edge) forces:
  - state = IDLE, `led` = 0000, `busy` = 0, `done` = 0, `cmd_ready` = 1.
  - Prescaler and repeat counter cleared.
  - Applies mid-command with no `done` pulse.
- IDLE:
  - A command is accepted at an edge where `cmd_valid && cmd_ready`.
  - `cmd_mode`=0: stays in IDLE, `led` = 0000, `done` pulses next cycle.
  - Other modes: go to RUN, latch mode and repeat, clear prescaler, load the initial pattern.
- Initial patterns:
  - mode 1: 0001
  - mode 2: 0000
  - mode 3: 1111
- Step rule, applied on each prescaler tick:
  - mode 1: rotate left; period = 4 steps.
  - mode 2: increment mod 16; period = 16 steps.
  - mode 3: invert; period = 2 steps.
- Period end: the step that would return the pattern to its initial value.
  - If the latched repeat is 1: `led` ← 0000, `done` ← 1 for one cycle, state ← IDLE.
  - Else if the latched repeat is >1: decrement repeat and continue.
  - If the latched repeat is 0: never decrements; runs forever.
- `abort`:
  - In RUN: at the next edge state ← IDLE, `led` ← 0000, no `done`.
  - Ignored in IDLE.
- `abort` coincident with a period-end tick: abort wins; no `done`.
- `cmd_valid` while busy is not accepted; the command must be held until `cmd_ready`.

## Timing
- Prescaler:
  - Cleared at the acceptance edge E0, then increments every edge.
  - Tick at an edge where count == `TICK_DIV`-1; the count wraps to 0 on that edge.
  - Ticks fall at E0+`TICK_DIV`, E0+2·`TICK_DIV`, and so on.
- `led`, `busy` and `done` are registered; `cmd_ready` = (state == IDLE).
- `led` shows the initial pattern in the cycle after E0.
- Total latency from acceptance to `done` = period × repeat × `TICK_DIV` cycles.
- `cmd_ready` is high in the same cycle as `done`; a new command may be accepted in that cycle.

## Configuration
- `LED_SCHED_ACTIVE_LOW_EN`:
  - Defined: `led` pins are driven with the bitwise inverse of the internal pattern; reset and idle drive 1111.
  - Undefined: active-high, as described above.
- Internal state and `done` timing are identical either way.

## Structure
- Package `led_sched_pkg` holds:
  - Mode enum (`MODE_OFF`, `MODE_RUN`, `MODE_CNT`, `MODE_BLINK`).
  - FSM state enum.
  - Initial-pattern constants.
  - Per-mode period-length constants.
- Sub-module `tick_prescaler`:
  - Parameter `TICK_DIV`.
  - Inputs `clk`, `rst_n`, `clr`; output `tick` (registered compare pulse).

## Test plan
All scenarios use `TICK_DIV`=4.
- **Reset:** hold `rst_n`=0 for 2 cycles → `led`=0000, `busy`=0, `done`=0, `cmd_ready`=1.
- **Running light, repeat=1:** mode 1 accepted at E0 → `led` = 0001, then 0010@E4, 0100@E8, 1000@E12; 0000 and `done`=1 @E16; `cmd_ready`=1 @E16.
- **Blink, repeat=2:** mode 3 → `led` = 1111, 0000@E4, 1111@E8, 0000@E12; `done` @E16 with `led`=0000.
- **Count, repeat=0, abort:** mode 2 → `led` reaches 0101@E20; `abort` sampled @E21 → `led`=0000, `busy`=0, no `done` pulse ever.
- **Back-pressure:** `cmd_valid` held during RUN → no acceptance until `cmd_ready`; the queued command is accepted in the same cycle as the previous `done`.
- **Reset mid-run:** `rst_n`=0 at E6 of a mode-1 command → `led`=0000 @E6, no `done`; a new command is accepted after reset releases.
